// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: opcode constants, instruction format enum
// and the decoded instruction record carried through the stage registers.
package decode_pkg;

  // Widest PC / immediate the decoded record can carry; the stage narrows or widens at its ports.
  localparam int DATA_WIDTH_MAX = 64;

  localparam logic [6:0] OPCODE_LUI       = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL       = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR      = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD      = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE     = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_OP        = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPCODE_OP_32     = 7'b0111011;
  localparam logic [6:0] OPCODE_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    FORMAT_R    = 3'd0,
    FORMAT_I    = 3'd1,
    FORMAT_S    = 3'd2,
    FORMAT_B    = 3'd3,
    FORMAT_U    = 3'd4,
    FORMAT_J    = 3'd5,
    FORMAT_NONE = 3'd6
  } instr_format_e;

  typedef struct packed {
    logic [DATA_WIDTH_MAX-1:0] pc;
    logic [4:0]                rs1;
    logic [4:0]                rs2;
    logic [4:0]                rd;
    logic [DATA_WIDTH_MAX-1:0] imm;
    logic [2:0]                funct3;
    logic                      funct7_b5;
    instr_format_e             format;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      branch;
    logic                      jump;
    logic                      is_word;
    logic                      illegal;
  } decoded_instr_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV64I decoder: classifies the opcode, sets control
// flags and assembles the sign-extended immediate for the detected format.
module instr_decoder
  import decode_pkg::*;
(
  input  logic [31:0]               instruction,
  input  logic [DATA_WIDTH_MAX-1:0] pc,
  output decoded_instr_t            decoded
);

  always_comb begin
    decoded           = '0;
    decoded.pc        = pc;
    decoded.rs1       = instruction[19:15];
    decoded.rs2       = instruction[24:20];
    decoded.rd        = instruction[11:7];
    decoded.funct3    = instruction[14:12];
    decoded.funct7_b5 = instruction[30];
    decoded.format    = FORMAT_NONE;

    // Compressed or all-zero encodings never reach the opcode table.
    if (instruction[1:0] != 2'b11) begin
      decoded.illegal = 1'b1;
    end else begin
      case (instruction[6:0])
        OPCODE_LUI, OPCODE_AUIPC: begin
          decoded.format    = FORMAT_U;
          decoded.reg_write = 1'b1;
        end
        OPCODE_JAL: begin
          decoded.format    = FORMAT_J;
          decoded.jump      = 1'b1;
          decoded.reg_write = 1'b1;
        end
        OPCODE_JALR: begin
          decoded.format    = FORMAT_I;
          decoded.jump      = 1'b1;
          decoded.reg_write = 1'b1;
        end
        OPCODE_BRANCH: begin
          decoded.format = FORMAT_B;
          decoded.branch = 1'b1;
        end
        OPCODE_LOAD: begin
          decoded.format    = FORMAT_I;
          decoded.mem_read  = 1'b1;
          decoded.reg_write = 1'b1;
        end
        OPCODE_STORE: begin
          decoded.format    = FORMAT_S;
          decoded.mem_write = 1'b1;
        end
        OPCODE_OP_IMM: begin
          decoded.format    = FORMAT_I;
          decoded.reg_write = 1'b1;
        end
        OPCODE_OP: begin
          decoded.format    = FORMAT_R;
          decoded.reg_write = 1'b1;
        end
        OPCODE_OP_IMM_32: begin
          decoded.format    = FORMAT_I;
          decoded.reg_write = 1'b1;
          decoded.is_word   = 1'b1;
        end
        OPCODE_OP_32: begin
          decoded.format    = FORMAT_R;
          decoded.reg_write = 1'b1;
          decoded.is_word   = 1'b1;
        end
        OPCODE_MISC_MEM, OPCODE_SYSTEM: begin
          decoded.format = FORMAT_I;
        end
        default: begin
          decoded.illegal = 1'b1;
        end
      endcase
    end

    case (decoded.format)
      FORMAT_I: decoded.imm = {{52{instruction[31]}}, instruction[31:20]};
      FORMAT_S: decoded.imm = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FORMAT_B: decoded.imm = {{52{instruction[31]}}, instruction[7], instruction[30:25],
                               instruction[11:8], 1'b0};
      FORMAT_U: decoded.imm = {{32{instruction[31]}}, instruction[31:12], 12'h000};
      FORMAT_J: decoded.imm = {{44{instruction[31]}}, instruction[19:12], instruction[20],
                               instruction[30:21], 1'b0};
      default:  decoded.imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: output register plus one-entry skid buffer so that
// the registered out_enable never lets fetch overrun the stage.
module decode_stage
  import decode_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = 64,
  parameter int REGISTER_WIDTH    = 64,
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instruction_bits,
  input  logic [ADDRESS_WIDTH-1:0]     in_pc,
  input  logic                         in_flush,
  input  logic                         in_stall,
  output logic                         out_enable,
  output logic                         out_valid,
  output logic [ADDRESS_WIDTH-1:0]     out_pc,
  output logic [4:0]                   out_rs1,
  output logic [4:0]                   out_rs2,
  output logic [4:0]                   out_rd,
  output logic [REGISTER_WIDTH-1:0]    out_imm,
  output logic [2:0]                   out_funct3,
  output logic                         out_funct7_b5,
  output logic [2:0]                   out_format,
  output logic                         out_reg_write,
  output logic                         out_mem_read,
  output logic                         out_mem_write,
  output logic                         out_branch,
  output logic                         out_jump,
  output logic                         out_is_word,
  output logic                         out_illegal
);

  localparam logic [1:0] STATE_EMPTY = 2'd0;
  localparam logic [1:0] STATE_ONE   = 2'd1;
  localparam logic [1:0] STATE_TWO   = 2'd2;

  logic [1:0]     state;
  logic [1:0]     state_next;
  decoded_instr_t decoded;
  decoded_instr_t out_entry;
  decoded_instr_t skid_entry;
  logic           accept;
  logic           consume;
  logic           load_out_from_input;
  logic           load_out_from_skid;
  logic           load_skid;

  instr_decoder u_instr_decoder (
    .instruction (32'(in_instruction_bits)),
    .pc          (DATA_WIDTH_MAX'(in_pc)),
    .decoded     (decoded)
  );

  assign accept  = in_valid & out_enable;
  assign consume = out_valid & ~in_stall;

  always_comb begin
    state_next          = state;
    load_out_from_input = 1'b0;
    load_out_from_skid  = 1'b0;
    load_skid           = 1'b0;
    // A flush wins over everything, including an instruction arriving this cycle.
    if (in_flush) begin
      state_next = STATE_EMPTY;
    end else begin
      case (state)
        STATE_EMPTY: begin
          if (accept) begin
            state_next          = STATE_ONE;
            load_out_from_input = 1'b1;
          end
        end
        STATE_ONE: begin
          if (accept && !consume) begin
            state_next = STATE_TWO;
            load_skid  = 1'b1;
          end else if (!accept && consume) begin
            state_next = STATE_EMPTY;
          end else if (accept && consume) begin
            load_out_from_input = 1'b1;
          end
        end
        STATE_TWO: begin
          if (consume) begin
            state_next         = STATE_ONE;
            load_out_from_skid = 1'b1;
          end
        end
        default: state_next = STATE_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= STATE_EMPTY;
      out_valid  <= 1'b0;
      out_enable <= 1'b1;
      out_entry  <= '0;
      skid_entry <= '0;
    end else begin
      state      <= state_next;
      out_valid  <= (state_next != STATE_EMPTY);
      out_enable <= (state_next != STATE_TWO);
      if (load_out_from_input) begin
        out_entry <= decoded;
      end else if (load_out_from_skid) begin
        out_entry <= skid_entry;
      end
      if (load_skid) begin
        skid_entry <= decoded;
      end
    end
  end

  assign out_pc        = ADDRESS_WIDTH'(out_entry.pc);
  assign out_rs1       = out_entry.rs1;
  assign out_rs2       = out_entry.rs2;
  assign out_rd        = out_entry.rd;
  assign out_imm       = REGISTER_WIDTH'($signed(out_entry.imm));
  assign out_funct3    = out_entry.funct3;
  assign out_funct7_b5 = out_entry.funct7_b5;
  assign out_format    = out_entry.format;
  assign out_reg_write = out_entry.reg_write;
  assign out_mem_read  = out_entry.mem_read;
  assign out_mem_write = out_entry.mem_write;
  assign out_branch    = out_entry.branch;
  assign out_jump      = out_entry.jump;
  assign out_is_word   = out_entry.is_word;
  assign out_illegal   = out_entry.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random
// traffic, all compared against a two-slot queue model with its own decoder.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instruction_bits;
  logic [63:0] in_pc;
  logic        in_flush;
  logic        in_stall;
  logic        out_enable;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [63:0] out_imm;
  logic [2:0]  out_funct3;
  logic        out_funct7_b5;
  logic [2:0]  out_format;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_branch;
  logic        out_jump;
  logic        out_is_word;
  logic        out_illegal;

  int    checks = 0;
  int    errors = 0;
  string step_tag = "init";

  decoded_instr_t model_queue[$];
  logic           model_enable = 1'b1;
  logic           model_zero   = 1'b1;

  decode_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_instruction_bits (in_instruction_bits),
    .in_pc               (in_pc),
    .in_flush            (in_flush),
    .in_stall            (in_stall),
    .out_enable          (out_enable),
    .out_valid           (out_valid),
    .out_pc              (out_pc),
    .out_rs1             (out_rs1),
    .out_rs2             (out_rs2),
    .out_rd              (out_rd),
    .out_imm             (out_imm),
    .out_funct3          (out_funct3),
    .out_funct7_b5       (out_funct7_b5),
    .out_format          (out_format),
    .out_reg_write       (out_reg_write),
    .out_mem_read        (out_mem_read),
    .out_mem_write       (out_mem_write),
    .out_branch          (out_branch),
    .out_jump            (out_jump),
    .out_is_word         (out_is_word),
    .out_illegal         (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decoder: opcode table lookup, immediates rebuilt as signed integers.
  function automatic decoded_instr_t ref_decode(input logic [31:0] w, input logic [63:0] pc);
    decoded_instr_t d;
    logic [5:0]     fl;
    longint         v;
    d           = '0;
    d.pc        = pc;
    d.rs1       = w[19:15];
    d.rs2       = w[24:20];
    d.rd        = w[11:7];
    d.funct3    = w[14:12];
    d.funct7_b5 = w[30];
    d.format    = FORMAT_NONE;
    fl          = 6'b000000;
    d.illegal   = 1'b0;
    if (w[1:0] != 2'b11) begin
      d.illegal = 1'b1;
    end else begin
      case (w[6:0])
        7'b0110111, 7'b0010111: begin d.format = FORMAT_U; fl = 6'b100000; end
        7'b1101111:             begin d.format = FORMAT_J; fl = 6'b100010; end
        7'b1100111:             begin d.format = FORMAT_I; fl = 6'b100010; end
        7'b1100011:             begin d.format = FORMAT_B; fl = 6'b000100; end
        7'b0000011:             begin d.format = FORMAT_I; fl = 6'b110000; end
        7'b0100011:             begin d.format = FORMAT_S; fl = 6'b001000; end
        7'b0010011:             begin d.format = FORMAT_I; fl = 6'b100000; end
        7'b0110011:             begin d.format = FORMAT_R; fl = 6'b100000; end
        7'b0011011:             begin d.format = FORMAT_I; fl = 6'b100001; end
        7'b0111011:             begin d.format = FORMAT_R; fl = 6'b100001; end
        7'b0001111, 7'b1110011: begin d.format = FORMAT_I; fl = 6'b000000; end
        default:                d.illegal = 1'b1;
      endcase
    end
    {d.reg_write, d.mem_read, d.mem_write, d.branch, d.jump, d.is_word} = fl;
    case (d.format)
      FORMAT_I: v = $signed(w[31:20]);
      FORMAT_S: v = $signed({w[31:25], w[11:7]});
      FORMAT_B: v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
      FORMAT_U: v = $signed({w[31:12], 12'h000});
      FORMAT_J: v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
      default:  v = 0;
    endcase
    d.imm = v;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s/%s: observed 0x%0h expected 0x%0h", step_tag, tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    decoded_instr_t exp;
    chk("valid", 64'(out_valid), 64'(model_queue.size() > 0));
    chk("enable", 64'(out_enable), 64'(model_enable));
    if (model_queue.size() > 0 || model_zero) begin
      exp = (model_queue.size() > 0) ? model_queue[0] : '0;
      chk("pc", out_pc, exp.pc);
      chk("imm", out_imm, exp.imm);
      chk("regs", 64'({out_rs1, out_rs2, out_rd}), 64'({exp.rs1, exp.rs2, exp.rd}));
      chk("fields", 64'({out_funct3, out_funct7_b5, out_format}),
          64'({exp.funct3, exp.funct7_b5, exp.format}));
      chk("flags", 64'({out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump,
                        out_is_word, out_illegal}),
          64'({exp.reg_write, exp.mem_read, exp.mem_write, exp.branch, exp.jump,
               exp.is_word, exp.illegal}));
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic applyStimulus(input logic rst_n, input logic valid, input logic [31:0] instr,
                               input logic [63:0] pc, input logic flush, input logic stall);
    logic accept;
    logic consume;
    reset               = rst_n;
    in_valid            = valid;
    in_instruction_bits = instr;
    in_pc               = pc;
    in_flush            = flush;
    in_stall            = stall;
    @(posedge clk);
    if (!rst_n) begin
      model_queue.delete();
      model_enable = 1'b1;
      model_zero   = 1'b1;
    end else if (flush) begin
      model_queue.delete();
      model_enable = 1'b1;
    end else begin
      accept  = valid && model_enable;
      consume = (model_queue.size() > 0) && !stall;
      if (consume) void'(model_queue.pop_front());
      if (accept) begin
        model_queue.push_back(ref_decode(instr, pc));
        model_zero = 1'b0;
      end
      model_enable = (model_queue.size() < 2);
    end
    #1;
    checkOutput();
  endtask

  localparam logic [31:0] ADDI = 32'hFFF00093;
  localparam logic [31:0] BEQ  = 32'hFE000EE3;

  logic [6:0] opcode_table [13] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                    7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                    7'b0110011, 7'b0011011, 7'b0111011, 7'b0001111,
                                    7'b1110011};

  initial begin
    logic [31:0] r;
    logic [31:0] w;

    step_tag = "reset";
    applyStimulus(1'b0, 1'b1, ADDI, 64'h40, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, BEQ, 64'h44, 1'b0, 1'b0);

    step_tag = "addi";
    applyStimulus(1'b1, 1'b1, ADDI, 64'h100, 1'b0, 1'b0);
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_pc", out_pc, 64'h100);
    chk("addi_rd", 64'(out_rd), 64'd1);
    chk("addi_rs1", 64'(out_rs1), 64'd0);
    chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_format", 64'(out_format), 64'(FORMAT_I));
    chk("addi_reg_write", 64'(out_reg_write), 64'd1);
    applyStimulus(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

    step_tag = "beq";
    applyStimulus(1'b1, 1'b1, BEQ, 64'h104, 1'b0, 1'b0);
    chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_branch", 64'(out_branch), 64'd1);
    chk("beq_reg_write", 64'(out_reg_write), 64'd0);
    chk("beq_format", 64'(out_format), 64'(FORMAT_B));
    applyStimulus(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

    step_tag = "zero_word";
    applyStimulus(1'b1, 1'b1, 32'h0000_0000, 64'h108, 1'b0, 1'b0);
    chk("zero_illegal", 64'(out_illegal), 64'd1);
    chk("zero_format", 64'(out_format), 64'(FORMAT_NONE));
    chk("zero_valid", 64'(out_valid), 64'd1);
    applyStimulus(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

    step_tag = "stall_fill";
    applyStimulus(1'b1, 1'b1, 32'h0020_8133, 64'h200, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0041_0193, 64'h204, 1'b0, 1'b1);
    chk("two_enable_low", 64'(out_enable), 64'd0);
    applyStimulus(1'b1, 1'b1, 32'h0000_3203, 64'h208, 1'b0, 1'b1);
    chk("third_held_pc", out_pc, 64'h200);
    step_tag = "stall_drain";
    applyStimulus(1'b1, 1'b1, 32'h0000_3203, 64'h208, 1'b0, 1'b0);
    chk("drain_second_pc", out_pc, 64'h204);
    applyStimulus(1'b1, 1'b1, 32'h0000_3203, 64'h208, 1'b0, 1'b0);
    chk("drain_third_pc", out_pc, 64'h208);
    applyStimulus(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

    step_tag = "flush_two";
    applyStimulus(1'b1, 1'b1, 32'h0020_8133, 64'h300, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0041_0193, 64'h304, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0000_3203, 64'h308, 1'b1, 1'b1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_enable", 64'(out_enable), 64'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

    step_tag = "reset_two";
    applyStimulus(1'b1, 1'b1, 32'h0020_8133, 64'h400, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0041_0193, 64'h404, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000_3203, 64'h408, 1'b0, 1'b1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_enable", 64'(out_enable), 64'd1);
    chk("rst_pc", out_pc, 64'd0);
    applyStimulus(1'b1, 1'b1, ADDI, 64'h500, 1'b0, 1'b0);
    chk("post_rst_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

    step_tag = "random";
    for (int i = 0; i < 600; i++) begin
      r = $urandom();
      if ($urandom_range(0, 99) < 85) w = {r[31:7], opcode_table[$urandom_range(0, 12)]};
      else w = r;
      applyStimulus(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), w,
                    {32'h0, $urandom()}, ($urandom_range(0, 24) == 0),
                    ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
